// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: sequencing controller for the 5-stage IF/ID/EXE/MEM/WB pipeline.
// Owns the per-stage valid bits and produces the allow-in / latch-enable
// handshakes. It stalls ID on a load-use hazard and flushes IF/ID/EXE when a
// taken branch leaves EXE.
//
// Optional feature: define PIPELINE_CTRL_PERF_EN to add the perf_stall_cnt and
// perf_flush_cnt performance counters.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   if_ready                    instruction for the current IF PC is available
//   id_rs, id_rt                source registers of the ID instruction
//   id_rs_used, id_rt_used      ID instruction actually reads rs / rt
//   exe_dest                    destination register of the EXE instruction (0 = none)
//   exe_is_load                 EXE instruction is a load
//   exe_busy                    multicycle EXE unit not finished
//   exe_br_taken                EXE instruction is a taken branch/jump
//   mem_ready                   data memory access complete
//   if_to_id_en .. mem_to_wb_en latch enables of the downstream stage registers
//   pc_en, pc_redirect          PC load enable, select branch target
//   stage_valid                 {WB,MEM,EXE,ID,IF} valid bits
//   id_stall                    ID held by a load-use hazard
//   perf_stall_cnt/flush_cnt    (PIPELINE_CTRL_PERF_EN only) event counters
module pipeline_ctrl #(
    parameter int unsigned REG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_ready,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic [REG_W-1:0] exe_dest,
    input  logic             exe_is_load,
    input  logic             exe_busy,
    input  logic             exe_br_taken,
    input  logic             mem_ready,
    output logic             if_to_id_en,
    output logic             id_to_exe_en,
    output logic             exe_to_mem_en,
    output logic             mem_to_wb_en,
    output logic             pc_en,
    output logic             pc_redirect,
    output logic [4:0]       stage_valid,
    output logic             id_stall
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    output logic [31:0]      perf_stall_cnt,
    output logic [31:0]      perf_flush_cnt
`endif
);

    logic valid_if, valid_id, valid_exe, valid_mem, valid_wb;
    logic hazard;
    logic rs_hit, rt_hit;
    logic allowin_if, allowin_id, allowin_exe, allowin_mem;
    logic move_if, move_id, move_exe, move_mem;
    logic flush;

    // Load-use detection; register 0 is never a real dependency.
    assign rs_hit = id_rs_used && (id_rs == exe_dest);
    assign rt_hit = id_rt_used && (id_rt == exe_dest);
    assign hazard = valid_id && valid_exe && exe_is_load && (exe_dest != '0)
                    && (rs_hit || rt_hit);

    // Allow-in chain: a stall anywhere propagates upstream in the same cycle.
    assign allowin_mem = !valid_mem || mem_ready;
    assign allowin_exe = !valid_exe || (!exe_busy && allowin_mem);
    assign allowin_id  = !valid_id  || (!hazard && allowin_exe);
    assign allowin_if  = !valid_if  || (if_ready && allowin_id);

    assign move_if  = valid_if  && if_ready   && allowin_id;
    assign move_id  = valid_id  && !hazard    && allowin_exe;
    assign move_exe = valid_exe && !exe_busy  && allowin_mem;
    assign move_mem = valid_mem && mem_ready;

    // A branch is resolved only on the cycle it actually leaves EXE.
    assign flush = move_exe && exe_br_taken;

    // Handshakes are combinational but forced low while reset is asserted.
    assign if_to_id_en   = !reset && move_if;
    assign id_to_exe_en  = !reset && move_id;
    assign exe_to_mem_en = !reset && move_exe;
    assign mem_to_wb_en  = !reset && move_mem;
    assign pc_en         = !reset && (allowin_if || flush);
    assign pc_redirect   = !reset && flush;
    assign id_stall      = !reset && hazard;

    assign stage_valid = {valid_wb, valid_mem, valid_exe, valid_id, valid_if};

    // Stage valid bits; flush overrides the normal IF/ID/EXE updates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_if  <= 1'b0;
            valid_id  <= 1'b0;
            valid_exe <= 1'b0;
            valid_mem <= 1'b0;
            valid_wb  <= 1'b0;
        end else begin
            if (flush) begin
                valid_if  <= 1'b1;
                valid_id  <= 1'b0;
                valid_exe <= 1'b0;
            end else begin
                if (allowin_if)  valid_if  <= 1'b1;
                if (allowin_id)  valid_id  <= valid_if && if_ready;
                if (allowin_exe) valid_exe <= valid_id && !hazard;
            end
            if (allowin_mem) valid_mem <= valid_exe && !exe_busy;
            valid_wb <= valid_mem && mem_ready;
        end
    end

`ifdef PIPELINE_CTRL_PERF_EN
    logic stall_evt;
    assign stall_evt = hazard || (exe_busy && valid_exe);

    // Free-running event counters, wrapping modulo 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_cnt <= 32'd0;
            perf_flush_cnt <= 32'd0;
        end else begin
            if (stall_evt) perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (flush)     perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Testbench for pipeline_ctrl: directed scenarios plus randomized traffic,
// each cycle compared against an instruction-slot model of the pipeline.
module tb_pipeline_ctrl;

    localparam int unsigned REG_W = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             if_ready;
    logic [REG_W-1:0] id_rs, id_rt, exe_dest;
    logic             id_rs_used, id_rt_used;
    logic             exe_is_load, exe_busy, exe_br_taken, mem_ready;
    logic             if_to_id_en, id_to_exe_en, exe_to_mem_en, mem_to_wb_en;
    logic             pc_en, pc_redirect, id_stall;
    logic [4:0]       stage_valid;
`ifdef PIPELINE_CTRL_PERF_EN
    logic [31:0]      perf_stall_cnt, perf_flush_cnt;
    logic [31:0]      m_stall, m_flush;
    logic [31:0]      base_stall, base_flush;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Model: each stage holds an instruction tag (0 = empty slot).
    int tag_q[5];
    int next_tag = 1;

    always #5 clk = ~clk;

    pipeline_ctrl #(.REG_W(REG_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .if_ready     (if_ready),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rs_used   (id_rs_used),
        .id_rt_used   (id_rt_used),
        .exe_dest     (exe_dest),
        .exe_is_load  (exe_is_load),
        .exe_busy     (exe_busy),
        .exe_br_taken (exe_br_taken),
        .mem_ready    (mem_ready),
        .if_to_id_en  (if_to_id_en),
        .id_to_exe_en (id_to_exe_en),
        .exe_to_mem_en(exe_to_mem_en),
        .mem_to_wb_en (mem_to_wb_en),
        .pc_en        (pc_en),
        .pc_redirect  (pc_redirect),
        .stage_valid  (stage_valid),
        .id_stall     (id_stall)
`ifdef PIPELINE_CTRL_PERF_EN
        ,
        .perf_stall_cnt(perf_stall_cnt),
        .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    task automatic chk(input string name, input string what,
                       input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s/%s: observed %0h expected %0h", name, what, obs, exp);
        end
    endtask

    // A stage can accept an instruction if, walking downstream, an empty
    // slot appears before any occupied stage that is not ready to leave.
    function automatic bit has_space(input int s, input bit [4:0] occ, input bit [4:0] rdy);
        for (int k = s; k < 5; k++) begin
            if (!occ[k]) return 1'b1;
            if (!rdy[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // One cycle: inputs were set at the falling edge; check, advance model.
    task automatic step(input string name);
        bit [4:0] occ, rdy, mv;
        bit [5:0] sp;
        bit       hz, fl;
        int       nt[5];
        #1;
        if (reset) begin
            chk(name, "valid", 32'(stage_valid), 32'd0);
            chk(name, "ctl", 32'({if_to_id_en, id_to_exe_en, exe_to_mem_en, mem_to_wb_en,
                                  pc_en, pc_redirect, id_stall}), 32'd0);
            for (int s = 0; s < 5; s++) tag_q[s] = 0;
`ifdef PIPELINE_CTRL_PERF_EN
            m_stall = 32'd0;
            m_flush = 32'd0;
            chk(name, "perf_stall", perf_stall_cnt, 32'd0);
            chk(name, "perf_flush", perf_flush_cnt, 32'd0);
`endif
        end else begin
            for (int s = 0; s < 5; s++) occ[s] = (tag_q[s] != 0);
            hz = occ[1] && occ[2] && exe_is_load && (exe_dest != 0) &&
                 ((id_rs_used && id_rs == exe_dest) || (id_rt_used && id_rt == exe_dest));
            rdy = {1'b1, mem_ready, !exe_busy, !hz, if_ready};
            sp[5] = 1'b1;
            for (int s = 0; s < 5; s++) sp[s] = has_space(s, occ, rdy);
            for (int s = 0; s < 5; s++) mv[s] = occ[s] && rdy[s] && sp[s+1];
            fl = mv[2] && exe_br_taken;

            chk(name, "valid", 32'(stage_valid), 32'(occ));
            chk(name, "ctl", 32'({if_to_id_en, id_to_exe_en, exe_to_mem_en, mem_to_wb_en,
                                  pc_en, pc_redirect, id_stall}),
                32'({mv[0], mv[1], mv[2], mv[3], sp[0] || fl, fl, hz}));
`ifdef PIPELINE_CTRL_PERF_EN
            chk(name, "perf_stall", perf_stall_cnt, m_stall);
            chk(name, "perf_flush", perf_flush_cnt, m_flush);
            if (hz || (exe_busy && occ[2])) m_stall = m_stall + 32'd1;
            if (fl) m_flush = m_flush + 32'd1;
`endif
            nt[4] = mv[3] ? tag_q[3] : 0;
            for (int s = 3; s >= 1; s--)
                nt[s] = sp[s] ? (mv[s-1] ? tag_q[s-1] : 0) : tag_q[s];
            nt[0] = tag_q[0];
            if (sp[0] || fl) begin
                nt[0] = next_tag;
                next_tag++;
            end
            if (fl) begin
                nt[1] = 0;
                nt[2] = 0;
            end
            for (int s = 0; s < 5; s++) tag_q[s] = nt[s];
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic quiet_inputs();
        if_ready     = 1'b1;
        mem_ready    = 1'b1;
        exe_busy     = 1'b0;
        exe_br_taken = 1'b0;
        exe_is_load  = 1'b0;
        exe_dest     = '0;
        id_rs        = '0;
        id_rt        = '0;
        id_rs_used   = 1'b0;
        id_rt_used   = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        quiet_inputs();
        @(negedge clk);
        step("reset");
        step("reset_hold");

        // Fill from reset: 00001, 00011, ... 11111.
        reset = 1'b0;
        for (int i = 0; i < 6; i++) step("fill");
        chk("fill", "full", 32'(stage_valid), 32'h1f);

        // Load-use on rs=5: one stall, then a bubble in EXE.
        exe_is_load = 1'b1; exe_dest = 5'd5; id_rs = 5'd5; id_rs_used = 1'b1;
        step("load_use");
        quiet_inputs();
        chk("load_use", "exe_bubble", 32'(stage_valid[2]), 32'd0);
        step("after_load");
        for (int i = 0; i < 4; i++) step("refill");

        // Register 0 never stalls.
        exe_is_load = 1'b1; exe_dest = 5'd0; id_rs = 5'd0; id_rs_used = 1'b1;
        step("load_r0");
        quiet_inputs();
        chk("load_r0", "no_bubble", 32'(stage_valid), 32'h1f);

        // Taken branch leaving EXE squashes ID and EXE, IF refetches.
        exe_br_taken = 1'b1;
        step("branch");
        exe_br_taken = 1'b0;
        chk("branch", "squash", 32'(stage_valid[2:0]), 32'h1);
        step("post_branch");
        for (int i = 0; i < 4; i++) step("refill2");

        // Branch held in EXE by a busy unit resolves once, when it leaves.
`ifdef PIPELINE_CTRL_PERF_EN
        base_stall = perf_stall_cnt;
        base_flush = perf_flush_cnt;
`endif
        exe_busy = 1'b1; exe_br_taken = 1'b1;
        for (int i = 0; i < 3; i++) step("busy_branch");
        exe_busy = 1'b0;
        step("branch_go");
        exe_br_taken = 1'b0;
`ifdef PIPELINE_CTRL_PERF_EN
        chk("busy_branch", "stall_delta", perf_stall_cnt - base_stall, 32'd3);
        chk("busy_branch", "flush_delta", perf_flush_cnt - base_flush, 32'd1);
`endif
        step("post_busy");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            if_ready     = ($urandom_range(0, 3) != 0);
            mem_ready    = ($urandom_range(0, 3) != 0);
            exe_busy     = ($urandom_range(0, 4) == 0);
            exe_br_taken = ($urandom_range(0, 5) == 0);
            exe_is_load  = ($urandom_range(0, 1) == 1);
            exe_dest     = REG_W'($urandom_range(0, 3));
            id_rs        = REG_W'($urandom_range(0, 3));
            id_rt        = REG_W'($urandom_range(0, 3));
            id_rs_used   = ($urandom_range(0, 1) == 1);
            id_rt_used   = ($urandom_range(0, 1) == 1);
            step("random");
        end

        // MEM stall in a full pipeline, then reset mid-stall.
        quiet_inputs();
        for (int i = 0; i < 6; i++) step("refill3");
        mem_ready = 1'b0;
        step("mem_stall");
        chk("mem_stall", "wb_drained", 32'(stage_valid[4]), 32'd0);
        step("mem_stall2");
        reset = 1'b1;
        step("reset_mid");
        quiet_inputs();
        step("reset_mid_hold");
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step("restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
